gb_timer: RTL and testbench
===========================

GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, width of the system counter input; values below 16 are illegal.
REQ-002 SHALL have port clk_in, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port div_count_in, input, DIV_WIDTH, free-running system count from the upstream evt_counter instance.
REQ-005 SHALL have port div_rst_out, output, 1, one-cycle pulse clearing the upstream counter.
REQ-006 SHALL have port wr_en_in, input, 1, register write strobe, single cycle.
REQ-007 SHALL have port addr_in, input, 2, register select: 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
REQ-008 SHALL have port wr_data_in, input, 8, write data.
REQ-009 SHALL have port rd_data_out, output, 8, combinational read data for addr_in.
REQ-010 SHALL have port irq_out, output, 1, one-cycle timer-overflow interrupt pulse.

Function
REQ-011 Registers SHALL be TIMA[7:0], TMA[7:0], TAC[2:0] (TAC[2]=enable, TAC[1:0]=rate select).
REQ-012 rd_data_out SHALL return div_count_in[15:8] for DIV, TIMA, TMA, and {5'b11111,TAC} for TAC.
REQ-013 Write to DIV SHALL assert div_rst_out for exactly the next cycle and store nothing locally.
REQ-014 Tap bit SHALL be div_count_in[9/3/5/7] for TAC[1:0]=00/01/10/11; tick signal = TAC[2] AND tap bit.
REQ-015 Tick signal SHALL be registered once; a 1->0 transition between consecutive cycles SHALL increment TIMA by 1 (mod 256) on the following edge.
REQ-016 Falling edges caused by DIV reset, TAC disable or TAC select change SHALL increment TIMA identically (no masking).
REQ-017 State machine SHALL have states IDLE and RELOAD; IDLE->RELOAD when an increment takes TIMA 0xFF->0x00; RELOAD->IDLE after exactly one cycle.
REQ-018 In RELOAD, TIMA SHALL read 0x00; on exit TIMA SHALL load the current TMA (including a TMA written that same cycle) and irq_out SHALL pulse for one cycle.
REQ-019 A TIMA write while in RELOAD SHALL store the written value, cancel the reload and suppress irq_out.
REQ-020 A TIMA write coinciding with an increment SHALL win; the increment is dropped and no overflow occurs.
REQ-021 irq_out SHALL never be high for two consecutive cycles.

Reset
REQ-022 While rst_in is high: TIMA=0x00, TMA=0x00, TAC=3'b000, state=IDLE, registered tick=0, irq_out=0, div_rst_out=0.
REQ-023 Reset asserted mid-RELOAD SHALL abort the reload with no irq_out after release.
REQ-024 First cycle after release SHALL NOT register a falling edge.

Configuration
REQ-025 Macro GB_TIMER_RELOAD_DELAY_EN defined: behaviour per REQ-017..REQ-019.
REQ-026 Macro GB_TIMER_RELOAD_DELAY_EN undefined: RELOAD state absent; overflow loads TMA into TIMA and pulses irq_out on the same edge as the increment; REQ-019 not applicable.

Verification
REQ-027 TAC=3'b101, div_count_in counting from 0 -> TIMA increments once per 16 cycles, first at div 0x0010 edge.
REQ-028 TIMA=0xFF, TMA=0xAB, TAC=3'b101, tap falls -> TIMA reads 0x00 one cycle, then 0xAB with one irq_out pulse (macro defined).
REQ-029 Same as REQ-028, TIMA write 0x42 during RELOAD -> TIMA=0x42, irq_out stays 0.
REQ-030 TAC=3'b100, div_count_in[9]=1, write DIV -> div_rst_out one cycle, TIMA +1 after counter clears.
REQ-031 TAC=3'b111, div bit7=1, write TAC=3'b011 -> TIMA +1 (disable glitch).
REQ-032 rst_in pulsed during RELOAD -> all outputs 0, no irq_out afterwards; macro undefined repeat of REQ-028 -> TIMA=0xAB and irq_out on overflow edge.

Source files
------------

// File: rtl/gb_timer.sv
// ---------------------------------------------------------------------------
// gb_timer
//
// Game Boy style programmable timer. TIMA counts falling edges of a tick
// derived from one tap of the upstream system counter (gated by TAC enable).
// On overflow TIMA reloads from TMA and a one-cycle interrupt pulse is raised.
//
// Build option:
//   GB_TIMER_RELOAD_DELAY_EN  defined   : overflow leaves TIMA at 0x00 for one
//                                         cycle (RELOAD state), then loads TMA
//                                         and pulses irq_out. A TIMA write in
//                                         that cycle cancels the reload.
//                             undefined : overflow loads TMA and pulses
//                                         irq_out on the same edge.
//
// Ports:
//   clk_in        in   system clock, rising edge
//   rst_in        in   asynchronous active-high reset
//   div_count_in  in   free-running system count (DIV_WIDTH >= 16)
//   div_rst_out   out  one-cycle pulse clearing the upstream counter
//   wr_en_in      in   register write strobe
//   addr_in       in   0=DIV 1=TIMA 2=TMA 3=TAC
//   wr_data_in    in   write data
//   rd_data_out   out  combinational read data for addr_in
//   irq_out       out  one-cycle overflow interrupt
// ---------------------------------------------------------------------------
module gb_timer #(
    // Width of the upstream counter; values below 16 are not supported.
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [DIV_WIDTH-1:0] div_count_in,
    output logic                 div_rst_out,
    input  logic                 wr_en_in,
    input  logic [1:0]           addr_in,
    input  logic [7:0]           wr_data_in,
    output logic [7:0]           rd_data_out,
    output logic                 irq_out
);

    typedef enum logic [1:0] {
        REG_DIV  = 2'd0,
        REG_TIMA = 2'd1,
        REG_TMA  = 2'd2,
        REG_TAC  = 2'd3
    } reg_sel_e;

`ifdef GB_TIMER_RELOAD_DELAY_EN
    typedef enum logic {
        IDLE   = 1'b0,
        RELOAD = 1'b1
    } state_e;

    state_e state_q, state_d;
`endif

    logic [7:0] tima_q, tima_d;
    logic [7:0] tma_q, tma_d;
    logic [2:0] tac_q, tac_d;
    logic       tick_q;
    logic       irq_q, irq_d;
    logic       div_rst_q, div_rst_d;

    logic       tap;
    logic       tick;
    logic       fall;
    logic       wr_tima;
    logic [7:0] tima_inc;

    // Only a handful of counter bits are observed; the rest are intentionally
    // ignored.
    logic       unused_div_bits;
    assign unused_div_bits = ^div_count_in;

    // -----------------------------------------------------------------------
    // Tick generation
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // before any branch, so no path leaves it unassigned and no latch appears.
    always_comb begin
        tap = 1'b0;
        case (tac_q[1:0])
            2'b00:   tap = div_count_in[9];
            2'b01:   tap = div_count_in[3];
            2'b10:   tap = div_count_in[5];
            default: tap = div_count_in[7];
        endcase
    end

    assign tick = tac_q[2] & tap;

    // A falling tick is seen whatever caused it: counter reset, disable, or a
    // rate change all count, matching the original hardware's glitch.
    assign fall    = tick_q & ~tick;
    assign wr_tima = wr_en_in && (addr_in == REG_TIMA);
    assign tima_inc = tima_q + 8'd1;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        tma_d     = tma_q;
        tac_d     = tac_q;
        tima_d    = tima_q;
        irq_d     = 1'b0;
        div_rst_d = 1'b0;
`ifdef GB_TIMER_RELOAD_DELAY_EN
        state_d   = state_q;
`endif

        // DIV is not stored here; a write only asks upstream to clear.
        if (wr_en_in && (addr_in == REG_DIV)) div_rst_d = 1'b1;
        if (wr_en_in && (addr_in == REG_TMA)) tma_d     = wr_data_in;
        if (wr_en_in && (addr_in == REG_TAC)) tac_d     = wr_data_in[2:0];

`ifdef GB_TIMER_RELOAD_DELAY_EN
        case (state_q)
            IDLE: begin
                // A CPU write beats a coincident increment.
                if (wr_tima) begin
                    tima_d = wr_data_in;
                end else if (fall) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = RELOAD;
                    end else begin
                        tima_d = tima_inc;
                    end
                end
            end
            RELOAD: begin
                state_d = IDLE;
                if (wr_tima) begin
                    // Written value sticks; reload and interrupt are cancelled.
                    tima_d = wr_data_in;
                end else begin
                    // tma_d so a TMA write in this same cycle is picked up.
                    tima_d = tma_d;
                    irq_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`else
        if (wr_tima) begin
            tima_d = wr_data_in;
        end else if (fall) begin
            if (tima_q == 8'hFF) begin
                tima_d = tma_d;
                irq_d  = 1'b1;
            end else begin
                tima_d = tima_inc;
            end
        end
`endif
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'b000;
            tick_q    <= 1'b0;
            irq_q     <= 1'b0;
            div_rst_q <= 1'b0;
`ifdef GB_TIMER_RELOAD_DELAY_EN
            state_q   <= IDLE;
`endif
        end else begin
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            tick_q    <= tick;
            irq_q     <= irq_d;
            div_rst_q <= div_rst_d;
`ifdef GB_TIMER_RELOAD_DELAY_EN
            state_q   <= state_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data_out = 8'h00;
        case (addr_in)
            REG_DIV:  rd_data_out = div_count_in[15:8];
            REG_TIMA: rd_data_out = tima_q;
            REG_TMA:  rd_data_out = tma_q;
            default:  rd_data_out = {5'b11111, tac_q};
        endcase
    end

    assign irq_out     = irq_q;
    assign div_rst_out = div_rst_q;

endmodule

// File: tb/tb_gb_timer.sv
// ---------------------------------------------------------------------------
// tb_gb_timer
//
// Self-checking bench for gb_timer. Directed scenarios followed by a random
// phase; every cycle is compared against a behavioural model of the timer.
// The bench also plays the upstream counter: it counts when enabled and
// clears on the edge that ends a div_rst_out pulse.
// Build option GB_TIMER_RELOAD_DELAY_EN selects the expected overflow timing.
// ---------------------------------------------------------------------------
module tb_gb_timer;

    logic        clk_in;
    logic        rst_in;
    logic [15:0] div_cnt;
    logic        div_rst_out;
    logic        wr_en_in;
    logic [1:0]  addr_in;
    logic [7:0]  wr_data_in;
    logic [7:0]  rd_data_out;
    logic        irq_out;

    gb_timer #(.DIV_WIDTH(16)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .div_count_in (div_cnt),
        .div_rst_out  (div_rst_out),
        .wr_en_in     (wr_en_in),
        .addr_in      (addr_in),
        .wr_data_in   (wr_data_in),
        .rd_data_out  (rd_data_out),
        .irq_out      (irq_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    bit div_run  = 1'b0;
    bit prev_irq = 1'b0;

    // ---------------- behavioural model ----------------
    int       tap_pos [4] = '{9, 3, 5, 7};
    bit [7:0] m_tima, m_tma;
    bit [2:0] m_tac;
    bit       m_prev_tick, m_reload, m_irq, m_divrst;

    function automatic void model_reset();
        m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
        m_prev_tick = 1'b0; m_reload = 1'b0; m_irq = 1'b0; m_divrst = 1'b0;
    endfunction

    // Advances the model across one rising edge given the inputs seen in the
    // cycle before it.
    function automatic void model_edge(bit wr, bit [1:0] a, bit [7:0] d, bit [15:0] div);
        bit       tick_now, fell;
        bit [7:0] tma_next;
        int       sum;
        tick_now = m_tac[2] && div[tap_pos[m_tac[1:0]]];
        fell     = m_prev_tick && !tick_now;
        tma_next = (wr && a == 2'd2) ? d : m_tma;
        m_irq    = 1'b0;
        m_divrst = wr && (a == 2'd0);
        if (wr && a == 2'd1) begin
            m_tima   = d;
            m_reload = 1'b0;
        end else if (m_reload) begin
            m_tima   = tma_next;
            m_reload = 1'b0;
            m_irq    = 1'b1;
        end else if (fell) begin
            sum = int'(m_tima) + 1;
            if (sum > 255) begin
`ifdef GB_TIMER_RELOAD_DELAY_EN
                m_tima   = 8'h00;
                m_reload = 1'b1;
`else
                m_tima = tma_next;
                m_irq  = 1'b1;
`endif
            end else begin
                m_tima = sum[7:0];
            end
        end
        if (wr && a == 2'd3) m_tac = d[2:0];
        m_tma       = tma_next;
        m_prev_tick = tick_now;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr_in = a;
        #1;
        check(tag, rd_data_out, exp);
    endtask

    task automatic tick_cycle();
        logic pre_rst;
        model_edge(wr_en_in, addr_in, wr_data_in, div_cnt);
        pre_rst = div_rst_out;
        @(posedge clk_in);
        #1;
        wr_en_in = 1'b0;
        if (pre_rst) div_cnt = 16'h0000;
        else if (div_run) div_cnt = div_cnt + 16'd1;
        check("irq", irq_out, m_irq);
        check("irq_b2b", irq_out & prev_irq, 1'b0);
        prev_irq = irq_out;
        check("div_rst", div_rst_out, m_divrst);
        check_reg("tima", 2'd1, m_tima);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en_in   = 1'b1;
        addr_in    = a;
        wr_data_in = d;
        tick_cycle();
    endtask

    task automatic apply_reset();
        rst_in  = 1'b1;
        div_run = 1'b0;
        div_cnt = 16'h0000;
        #1;
        model_reset();
        prev_irq = 1'b0;
        check("rst_irq", irq_out, 1'b0);
        check("rst_div_rst", div_rst_out, 1'b0);
        check_reg("rst_tima", 2'd1, 8'h00);
        check_reg("rst_tma", 2'd2, 8'h00);
        check_reg("rst_tac", 2'd3, 8'hF8);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Loads TIMA=FF, TMA=AB, TAC=101 and walks the tap through a falling edge;
    // returns just after the overflow edge.
    task automatic overflow_setup();
        div_run = 1'b0;
        div_cnt = 16'h0000;
        wr(2'd1, 8'hFF);
        wr(2'd2, 8'hAB);
        wr(2'd3, 8'h05);
        div_cnt = 16'h000F;
        div_run = 1'b1;
        tick_cycle();
        tick_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         t;
        int         r;
        logic [1:0] a;
        logic [7:0] d;

        wr_en_in   = 1'b0;
        addr_in    = 2'd0;
        wr_data_in = 8'h00;
        apply_reset();

        // Rate 01 (bit 3): first increment on the edge closing div=0x0010.
        div_cnt = 16'h0000;
        div_run = 1'b1;
        wr(2'd3, 8'h05);
        for (int i = 0; i < 32 && div_cnt != 16'h0010; i++) tick_cycle();
        check_reg("tima_before_0x10", 2'd1, 8'h00);
        tick_cycle();
        check_reg("tima_at_0x10", 2'd1, 8'h01);
        repeat (40) tick_cycle();
        check_reg("tima_rate_16", 2'd1, 8'h03);

        // Overflow.
        overflow_setup();
`ifdef GB_TIMER_RELOAD_DELAY_EN
        check_reg("reload_tima_zero", 2'd1, 8'h00);
        check("reload_irq_low", irq_out, 1'b0);
        tick_cycle();
        check_reg("reload_tima_tma", 2'd1, 8'hAB);
        check("reload_irq", irq_out, 1'b1);
`else
        check_reg("ovf_tima_tma", 2'd1, 8'hAB);
        check("ovf_irq", irq_out, 1'b1);
`endif
        tick_cycle();
        check("irq_one_cycle", irq_out, 1'b0);

`ifdef GB_TIMER_RELOAD_DELAY_EN
        // TIMA write during RELOAD cancels reload and interrupt.
        overflow_setup();
        wr(2'd1, 8'h42);
        check_reg("reload_cancel_tima", 2'd1, 8'h42);
        check("reload_cancel_irq", irq_out, 1'b0);
        tick_cycle();
        check("reload_cancel_irq_late", irq_out, 1'b0);
`endif

        // TIMA write coincident with an overflowing increment wins.
        div_run = 1'b0;
        div_cnt = 16'h0000;
        wr(2'd1, 8'hFF);
        div_cnt = 16'h000F;
        div_run = 1'b1;
        tick_cycle();
        wr(2'd1, 8'h42);
        check_reg("wr_beats_inc", 2'd1, 8'h42);
        tick_cycle();
        check("wr_beats_inc_irq", irq_out, 1'b0);

        // DIV write: pulse, upstream clears, tap falls, TIMA+1.
        div_run = 1'b0;
        wr(2'd3, 8'h04);
        div_cnt = 16'h0200;
        tick_cycle();
        t = int'(m_tima);
        wr(2'd0, 8'h00);
        check("div_rst_pulse", div_rst_out, 1'b1);
        tick_cycle();
        check("div_rst_done", div_rst_out, 1'b0);
        check_reg("div_rst_no_inc_yet", 2'd1, 8'(t));
        tick_cycle();
        check_reg("div_rst_inc", 2'd1, 8'(t + 1));

        // Disable glitch: TAC 111 -> 011 with bit 7 high.
        div_cnt = 16'h0000;
        wr(2'd3, 8'h07);
        div_cnt = 16'h0080;
        tick_cycle();
        t = int'(m_tima);
        wr(2'd3, 8'h03);
        tick_cycle();
        check_reg("disable_glitch", 2'd1, 8'(t + 1));

        // Rate change glitch: bit 3 high, bit 7 low, select 01 -> 11.
        div_cnt = 16'h0008;
        wr(2'd3, 8'h05);
        tick_cycle();
        t = int'(m_tima);
        wr(2'd3, 8'h07);
        tick_cycle();
        check_reg("select_glitch", 2'd1, 8'(t + 1));

        // DIV read returns the upper counter byte.
        div_cnt = 16'hA55A;
        check_reg("div_read", 2'd0, 8'hA5);

        // Reset landing on the overflow (RELOAD when enabled).
        overflow_setup();
        apply_reset();
        repeat (4) begin
            tick_cycle();
            check("no_irq_after_rst", irq_out, 1'b0);
        end

        // Random phase.
        div_cnt = 16'($urandom);
        div_run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                a = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                if (a == 2'd1 && $urandom_range(0, 1) == 1) d = 8'hFC | (d & 8'h03);
                if (a == 2'd3 && $urandom_range(0, 3) != 0) d = 8'h05;
                wr(a, d);
            end else begin
                tick_cycle();
            end
            if (i % 64 == 0) begin
                check_reg("rand_tma", 2'd2, m_tma);
                check_reg("rand_tac", 2'd3, {5'b11111, m_tac});
                check_reg("rand_div", 2'd0, div_cnt[15:8]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
